walking_indicator_checker: RTL

- Receive-side monitor for the 3-bit one-hot walking indicator bus: 000 after generator reset, then 001 -> 010 -> 100 -> 001 ... one step per clock.
- Samples the bus, acquires lock on the rotation and decodes the current position.
- Counts completed laps and flags protocol violations with a sticky error code.
- Sits on the consumer side of the indicator bus, same clock domain as the generator.

---
 rtl/walking_indicator_checker.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/walking_indicator_checker.sv
// Receive-side monitor for a 3-bit one-hot walking indicator bus.
// It locks onto the 001 -> 010 -> 100 rotation, decodes the current position,
// counts completed laps and latches a sticky error code on protocol violations.
//
// Optional build macro: WIM_STALL_TOLERANT_EN
//   defined   - in LOCKED up to STALL_MAX consecutive repeats are tolerated
//   undefined - any repeat in LOCKED is a STALL fault
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the first one-hot pattern (000 is normal here)
// ACQUIRE  | counting correct successors until SYNC_LEN is reached
// LOCKED   | tracking the rotation, decoding position, counting laps
// FAULT    | sticky error; input ignored until clr_err
module walking_indicator_checker #(
  parameter int SYNC_LEN  = 2,
  parameter int LAP_W     = 8,
  parameter int STALL_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       indicators,
  input  logic             sample_en,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       position,
  output logic [LAP_W-1:0] lap_count,
  output logic             restart,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SEQ     = 2'b10;
  localparam logic [1:0] CODE_STALL   = 2'b11;

  localparam logic [3:0] SYNC_TGT = 4'(SYNC_LEN);

  // The stall counter is sized from STALL_MAX; without tolerance its limit
  // is zero, so the first repeat already sits at the limit and faults.
  localparam int STALL_W = $clog2(STALL_MAX + 1);
`ifdef WIM_STALL_TOLERANT_EN
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);
`else
  localparam logic [STALL_W-1:0] STALL_LIM = '0;
`endif

  state_t             r_state;
  logic [2:0]         r_last;
  logic [3:0]         r_sync;
  logic [STALL_W-1:0] r_stall;
  logic [LAP_W-1:0]   r_lap;
  logic               r_restart;
  logic [1:0]         r_code;

  state_t             w_next_state;
  logic [2:0]         w_next_last;
  logic [3:0]         w_next_sync;
  logic [STALL_W-1:0] w_next_stall;
  logic [LAP_W-1:0]   w_next_lap;
  logic               w_next_restart;
  logic [1:0]         w_next_code;

  logic               w_zero;
  logic               w_onehot;
  logic               w_illegal;
  logic [2:0]         w_succ;
  logic               w_is_succ;
  logic               w_is_rep;
  logic [3:0]         w_sync_inc;
  logic [LAP_W-1:0]   w_lap_inc;

  assign w_zero     = (indicators == 3'b000);
  assign w_onehot   = $onehot(indicators);
  assign w_illegal  = !w_zero && !w_onehot;
  // Rotate left: 001 -> 010 -> 100 -> 001.
  assign w_succ     = {r_last[1:0], r_last[2]};
  assign w_is_succ  = (indicators == w_succ);
  assign w_is_rep   = (indicators == r_last);
  assign w_sync_inc = r_sync + 4'd1;
  assign w_lap_inc  = (r_lap == {LAP_W{1'b1}}) ? r_lap : r_lap + 1'b1;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_last    <= 3'b000;
      r_sync    <= 4'd0;
      r_stall   <= '0;
      r_lap     <= '0;
      r_restart <= 1'b0;
      r_code    <= CODE_NONE;
    end else begin
      r_state   <= w_next_state;
      r_last    <= w_next_last;
      r_sync    <= w_next_sync;
      r_stall   <= w_next_stall;
      r_lap     <= w_next_lap;
      r_restart <= w_next_restart;
      r_code    <= w_next_code;
    end
  end

  // Next-state and datapath decisions; everything holds unless a rule fires.
  always_comb begin
    w_next_state   = r_state;
    w_next_last    = r_last;
    w_next_sync    = r_sync;
    w_next_stall   = r_stall;
    w_next_lap     = r_lap;
    w_next_restart = 1'b0;
    w_next_code    = r_code;

    case (r_state)
      ST_IDLE: begin
        if (sample_en) begin
          if (w_onehot) begin
            w_next_last  = indicators;
            w_next_sync  = 4'd0;
            w_next_state = ST_ACQUIRE;
          end else if (w_illegal) begin
            w_next_code  = CODE_ILLEGAL;
            w_next_state = ST_FAULT;
          end
        end
      end

      ST_ACQUIRE: begin
        if (sample_en) begin
          if (w_zero) begin
            w_next_last  = 3'b000;
            w_next_sync  = 4'd0;
            w_next_state = ST_IDLE;
          end else if (w_illegal) begin
            w_next_code  = CODE_ILLEGAL;
            w_next_state = ST_FAULT;
          end else if (w_is_succ) begin
            w_next_last = indicators;
            w_next_sync = w_sync_inc;
            if (w_sync_inc == SYNC_TGT) begin
              w_next_stall = '0;
              w_next_state = ST_LOCKED;
            end
          end else begin
            // Out-of-order one-hot: resynchronise from this pattern.
            w_next_last = indicators;
            w_next_sync = 4'd0;
          end
        end
      end

      ST_LOCKED: begin
        if (sample_en) begin
          if (w_zero) begin
            w_next_restart = 1'b1;
            w_next_lap     = '0;
            w_next_last    = 3'b000;
            w_next_sync    = 4'd0;
            w_next_stall   = '0;
            w_next_state   = ST_IDLE;
          end else if (w_illegal) begin
            w_next_code  = CODE_ILLEGAL;
            w_next_state = ST_FAULT;
          end else if (w_is_succ) begin
            w_next_last  = indicators;
            w_next_stall = '0;
            if (r_last == 3'b100) begin
              w_next_lap = w_lap_inc;
            end
          end else if (w_is_rep) begin
            if (r_stall == STALL_LIM) begin
              w_next_code  = CODE_STALL;
              w_next_state = ST_FAULT;
            end else begin
              w_next_stall = r_stall + 1'b1;
            end
          end else begin
            w_next_code  = CODE_SEQ;
            w_next_state = ST_FAULT;
          end
        end
      end

      ST_FAULT: begin
        // clr_err is honoured even with sample_en low.
        if (clr_err) begin
          w_next_code  = CODE_NONE;
          w_next_lap   = '0;
          w_next_last  = 3'b000;
          w_next_sync  = 4'd0;
          w_next_stall = '0;
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Position decode of the last accepted pattern, only meaningful while locked.
  always_comb begin
    position = 2'b00;
    if (r_state == ST_LOCKED) begin
      case (r_last)
        3'b001:  position = 2'b01;
        3'b010:  position = 2'b10;
        3'b100:  position = 2'b11;
        default: position = 2'b00;
      endcase
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err       = (r_state == ST_FAULT);
  assign err_code  = r_code;
  assign lap_count = r_lap;
  assign restart   = r_restart;

endmodule
